// File: rtl/mont_reduce_tail.sv
// Kyber Montgomery reduction tail: pairs a with its QINV term t,
// computes r = (a - t*Q) >>> 16 and queues results into an output FIFO.
module mont_reduce_tail #(
    parameter int Q     = 3329,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_a,
    input  logic [15:0]                  in_t,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_r,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [31:0] QS = 32'(Q);

    logic signed [31:0] a_reg;
    logic               a_vld;
    logic [15:0]        mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic               accept;
    logic               push;
    logic               pop;
    logic [CW:0]        occ;
    logic signed [31:0] t_s;
    logic signed [31:0] m;
    logic signed [32:0] d;
    logic [15:0]        r;
    logic               unused_bits;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Only registered terms: the in-flight a always finds a free slot.
    assign occ       = {1'b0, fifo_cnt} + {{CW{1'b0}}, a_vld};
    assign in_ready  = occ < (CW+1)'(DEPTH);
    assign accept    = in_valid && in_ready;
    assign push      = a_vld;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_r     = out_valid ? mem[rd_ptr] : 16'h0000;

    assign t_s = {{16{in_t[15]}}, in_t};
    assign m   = t_s * QS;
    assign d   = {a_reg[31], a_reg} - {m[31], m};
    assign r   = d[31:16];
    // Low half is zero by construction of t; sign bit is redundant.
    assign unused_bits = ^{d[32], d[15:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            a_vld <= 1'b0;
        end else begin
            a_vld <= accept;
            if (accept) begin
                a_reg <= in_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= r;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule
